// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP long-op (FDIV.S / FSQRT.S) controller.
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2,
    DROP = 2'd3
  } longop_state_t;

  localparam logic [31:0] FP_CANONICAL_NAN = 32'h7FC0_0000;

  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [4:0] FUNCT5_FDIV  = 5'b00011;
  localparam logic [4:0] FUNCT5_FSQRT = 5'b01011;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

endpackage

// File: rtl/fp_watchdog_counter.sv
// Watchdog timer for the long-op BUSY phase. Down-counter loaded on clear;
// expired flags the cycle in which the limit-th enabled cycle is being spent.
module fp_watchdog_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on clear, otherwise count down toward terminal count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = limit - CNT_W'(1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (cnt_q == '0);

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp_longop_controller.sv
// Sequencer for FDIV.S/FSQRT.S through the shared iterative FP unit.
// Optional watchdog enabled by defining FPLONG_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no long op outstanding; accepts a new issue from EX
// BUSY  | unit iterating; waiting for unit_done (or watchdog expiry)
// WB    | result held on wb_* until wb_ready
// DROP  | after a watchdog NaN writeback, swallows the unit's late unit_done
module fp_longop_controller
  import fp_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef FPLONG_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_is_long,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [2:0]            ex_rm,
  input  logic [DATA_W-1:0]     ex_op_a,
  input  logic [DATA_W-1:0]     ex_op_b,
  input  logic                  flush,
  output logic                  unit_start,
  output logic [DATA_W-1:0]     unit_op_a,
  output logic [DATA_W-1:0]     unit_op_b,
  output logic [2:0]            unit_rm,
  input  logic                  unit_done,
  input  logic [DATA_W-1:0]     unit_result,
  output logic                  pipe_stall,
  output logic                  busy_rd_valid,
  output logic [REG_ADDR_W-1:0] busy_rd,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_ready,
  output logic                  err_timeout
);

  longop_state_t         state_q, state_d;
  logic                  unit_start_q, unit_start_d;
  logic [DATA_W-1:0]     op_a_q, op_a_d;
  logic [DATA_W-1:0]     op_b_q, op_b_d;
  logic [2:0]            rm_q, rm_d;
  logic                  busy_rd_valid_q, busy_rd_valid_d;
  logic [REG_ADDR_W-1:0] busy_rd_q, busy_rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  drop_q, drop_d;
  logic                  issue;

  assign issue      = ex_valid & ex_is_long & ~flush;
  assign pipe_stall = (state_q != IDLE) | issue;

`ifdef FPLONG_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic wd_expired;
  logic err_timeout_q, err_timeout_d;
  // Set when a NaN writeback went out while the unit still owes us a done.
  logic late_pend_q, late_pend_d;

  fp_watchdog_counter #(.CNT_W(WD_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_q == IDLE) && issue),
    .enable  (state_q == BUSY),
    .limit   (WD_W'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    unit_start_d    = 1'b0;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    rm_d            = rm_q;
    busy_rd_valid_d = busy_rd_valid_q;
    busy_rd_d       = busy_rd_q;
    wb_valid_d      = wb_valid_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    drop_d          = drop_q;
`ifdef FPLONG_WATCHDOG_EN
    err_timeout_d   = err_timeout_q;
    late_pend_d     = late_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (issue) begin
          op_a_d          = ex_op_a;
          op_b_d          = ex_op_b;
          rm_d            = ex_rm;
          busy_rd_d       = ex_rd;
          busy_rd_valid_d = 1'b1;
          unit_start_d    = 1'b1;
          drop_d          = 1'b0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (unit_done) begin
          // A flush arriving with the done still kills the writeback.
          if (drop_q || flush || (busy_rd_q == '0)) begin
            busy_rd_valid_d = 1'b0;
            drop_d          = 1'b0;
            state_d         = IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = busy_rd_q;
            wb_data_d  = unit_result;
            state_d    = WB;
          end
        end
`ifdef FPLONG_WATCHDOG_EN
        else if (wd_expired) begin
          err_timeout_d = 1'b1;
          if (drop_q || flush || (busy_rd_q == '0)) begin
            busy_rd_valid_d = 1'b0;
            drop_d          = 1'b0;
            state_d         = IDLE;
          end else begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = busy_rd_q;
            wb_data_d   = DATA_W'(FP_CANONICAL_NAN);
            late_pend_d = 1'b1;
            state_d     = WB;
          end
        end
`endif
        else if (flush) begin
          drop_d = 1'b1;
        end
      end
      WB: begin
`ifdef FPLONG_WATCHDOG_EN
        if (unit_done) begin
          late_pend_d = 1'b0;
        end
`endif
        if (wb_ready) begin
          wb_valid_d      = 1'b0;
          busy_rd_valid_d = 1'b0;
          state_d         = IDLE;
`ifdef FPLONG_WATCHDOG_EN
          if (late_pend_q && !unit_done) begin
            state_d = DROP;
          end
          late_pend_d = 1'b0;
`endif
        end
      end
      DROP: begin
        if (unit_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      unit_start_q    <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      rm_q            <= '0;
      busy_rd_valid_q <= 1'b0;
      busy_rd_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      drop_q          <= 1'b0;
`ifdef FPLONG_WATCHDOG_EN
      err_timeout_q   <= 1'b0;
      late_pend_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      unit_start_q    <= unit_start_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      rm_q            <= rm_d;
      busy_rd_valid_q <= busy_rd_valid_d;
      busy_rd_q       <= busy_rd_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      drop_q          <= drop_d;
`ifdef FPLONG_WATCHDOG_EN
      err_timeout_q   <= err_timeout_d;
      late_pend_q     <= late_pend_d;
`endif
    end
  end

  assign unit_start    = unit_start_q;
  assign unit_op_a     = op_a_q;
  assign unit_op_b     = op_b_q;
  assign unit_rm       = rm_q;
  assign busy_rd_valid = busy_rd_valid_q;
  assign busy_rd       = busy_rd_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_fp_longop_controller.sv
// Bench for fp_longop_controller. Each operation is described by its issue
// data, the cycle the unit reports done, an optional flush cycle and the
// cycle wb_ready is granted; expected waveform metrics follow from those.
// Build with FPLONG_WATCHDOG_EN to add the watchdog scenario.
`timescale 1ns/1ps
module tb_fp_longop_controller;

`ifdef FPLONG_WATCHDOG_EN
  localparam int MAX_D = 6;
  localparam int D_FIX = 6;
`else
  localparam int MAX_D = 20;
  localparam int D_FIX = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_is_long = 1'b0, flush = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_rm = '0;
  logic [31:0] ex_op_a = '0, ex_op_b = '0;
  logic        unit_done = 1'b0, wb_ready = 1'b0;
  logic [31:0] unit_result = '0;
  logic        unit_start, pipe_stall, busy_rd_valid, wb_valid, err_timeout;
  logic [31:0] unit_op_a, unit_op_b, wb_data;
  logic [2:0]  unit_rm;
  logic [4:0]  busy_rd, wb_rd;

  always #5 clk = ~clk;

  fp_longop_controller #(
    .DATA_W(32),
    .REG_ADDR_W(5)
`ifdef FPLONG_WATCHDOG_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_long(ex_is_long), .ex_rd(ex_rd), .ex_rm(ex_rm),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .flush(flush),
    .unit_start(unit_start), .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
    .unit_rm(unit_rm), .unit_done(unit_done), .unit_result(unit_result),
    .pipe_stall(pipe_stall), .busy_rd_valid(busy_rd_valid), .busy_rd(busy_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Observations from the last run_op.
  int          n_stall, last_stall, n_start, start_at;
  int          n_wbv, wbv_first, n_busyv, last_busyv, n_err;
  logic [31:0] wb_data_seen, lat_a, lat_b;
  logic [4:0]  wb_rd_seen, lat_rd;
  logic [2:0]  lat_rm;
  logic        wb_unstable;

  // Drives one long op (issue in cycle 0) and records what the DUT showed.
  task automatic run_op(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [31:0] result,
                        input int done_at, input int flush_at, input int ready_at,
                        input int n_cycles);
    n_stall = 0; last_stall = -1; n_start = 0; start_at = -1;
    n_wbv = 0; wbv_first = -1; n_busyv = 0; last_busyv = -1; n_err = 0;
    wb_data_seen = '0; wb_rd_seen = '0; wb_unstable = 1'b0;
    lat_a = '0; lat_b = '0; lat_rd = '0; lat_rm = '0;
    @(posedge clk); #1;
    for (int c = 0; c < n_cycles; c++) begin
      ex_valid    = (c == 0);
      ex_is_long  = (c == 0);
      ex_rd       = (c == 0) ? rd : 5'($urandom);
      ex_rm       = (c == 0) ? rm : 3'($urandom);
      ex_op_a     = (c == 0) ? a : $urandom;
      ex_op_b     = (c == 0) ? b : $urandom;
      flush       = (c == flush_at);
      unit_done   = (c == done_at);
      unit_result = (c == done_at) ? result : $urandom;
      wb_ready    = (c == ready_at);
      @(negedge clk);
      if (pipe_stall) begin n_stall++; last_stall = c; end
      if (unit_start) begin n_start++; start_at = c; end
      if (c == 1) begin
        lat_a = unit_op_a; lat_b = unit_op_b; lat_rm = unit_rm; lat_rd = busy_rd;
      end
      if (wb_valid) begin
        if (n_wbv == 0) begin
          wbv_first = c; wb_data_seen = wb_data; wb_rd_seen = wb_rd;
        end else if (wb_data != wb_data_seen || wb_rd != wb_rd_seen) begin
          wb_unstable = 1'b1;
        end
        n_wbv++;
      end
      if (busy_rd_valid) begin n_busyv++; last_busyv = c; end
      if (err_timeout) n_err++;
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; ex_is_long = 1'b0; flush = 1'b0; unit_done = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({unit_start, busy_rd_valid, wb_valid, err_timeout, pipe_stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {unit_start, busy_rd_valid, wb_valid, err_timeout, pipe_stall});
    end
    checks++;
    if ({unit_op_a, unit_op_b, unit_rm, busy_rd, wb_rd, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {unit_op_a, unit_op_b, unit_rm, busy_rd, wb_rd, wb_data});
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_fdiv_basic();
    run_op(5'd5, 32'h40400000, 32'h40000000, 3'b000, 32'h3FC00000, D_FIX, -1, D_FIX + 1, D_FIX + 5);
    checks++;
    if (n_start !== 1 || start_at !== 1) begin
      errors++; $display("FAIL fdiv_start: got n=%0d at=%0d want n=1 at=1", n_start, start_at);
    end
    checks++;
    if (lat_a !== 32'h40400000 || lat_b !== 32'h40000000 || lat_rm !== 3'b000 || lat_rd !== 5'd5) begin
      errors++;
      $display("FAIL fdiv_latch: got a=%h b=%h rm=%0d rd=%0d want 40400000 40000000 0 5",
               lat_a, lat_b, lat_rm, lat_rd);
    end
    checks++;
    if (n_stall !== D_FIX + 2 || last_stall !== D_FIX + 1) begin
      errors++;
      $display("FAIL fdiv_stall: got n=%0d last=%0d want n=%0d last=%0d",
               n_stall, last_stall, D_FIX + 2, D_FIX + 1);
    end
    checks++;
    if (n_wbv !== 1 || wbv_first !== D_FIX + 1) begin
      errors++;
      $display("FAIL fdiv_wbvalid: got n=%0d first=%0d want n=1 first=%0d", n_wbv, wbv_first, D_FIX + 1);
    end
    checks++;
    if (wb_rd_seen !== 5'd5 || wb_data_seen !== 32'h3FC00000) begin
      errors++;
      $display("FAIL fdiv_wbdata: got rd=%0d data=%h want rd=5 data=3fc00000", wb_rd_seen, wb_data_seen);
    end
    checks++;
    if (last_busyv !== D_FIX + 1 || n_busyv !== D_FIX + 1) begin
      errors++;
      $display("FAIL fdiv_scoreboard: got n=%0d last=%0d want %0d", n_busyv, last_busyv, D_FIX + 1);
    end
  endtask

  task automatic test_wb_backpressure();
    run_op(5'd5, 32'h40400000, 32'h40000000, 3'b000, 32'h3FC00000, D_FIX, -1, D_FIX + 4, D_FIX + 8);
    checks++;
    if (n_wbv !== 4 || wb_unstable !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got n=%0d unstable=%b want n=4 unstable=0", n_wbv, wb_unstable);
    end
    checks++;
    if (last_stall !== D_FIX + 4 || wb_data_seen !== 32'h3FC00000) begin
      errors++;
      $display("FAIL bp_stall: got last=%0d data=%h want last=%0d data=3fc00000",
               last_stall, wb_data_seen, D_FIX + 4);
    end
  endtask

  task automatic test_flush_drop();
    run_op(5'd7, 32'h40800000, $urandom, 3'b001, 32'h40000000, D_FIX, 2, D_FIX + 1, D_FIX + 5);
    checks++;
    if (n_wbv !== 0) begin
      errors++; $display("FAIL flush_nowb: got wb_valid cycles=%0d want 0", n_wbv);
    end
    checks++;
    if (last_stall !== D_FIX || n_stall !== D_FIX + 1 || last_busyv !== D_FIX) begin
      errors++;
      $display("FAIL flush_idle: got stall_last=%0d n=%0d busy_last=%0d want %0d %0d %0d",
               last_stall, n_stall, last_busyv, D_FIX, D_FIX + 1, D_FIX);
    end
  endtask

  task automatic test_done_flush_same();
    run_op(5'd9, $urandom, $urandom, 3'b000, $urandom, 4, 4, 5, 9);
    checks++;
    if (n_wbv !== 0 || last_stall !== 4) begin
      errors++; $display("FAIL done_flush: got wb=%0d stall_last=%0d want 0 4", n_wbv, last_stall);
    end
  endtask

  task automatic test_rd_zero();
    run_op(5'd0, $urandom, $urandom, 3'b010, $urandom, 5, -1, 6, 10);
    checks++;
    if (n_start !== 1 || n_wbv !== 0 || last_stall !== 5) begin
      errors++;
      $display("FAIL rd0: got start=%0d wb=%0d stall_last=%0d want 1 0 5", n_start, n_wbv, last_stall);
    end
  endtask

  task automatic test_idle_done();
    @(posedge clk); #1;
    unit_done = 1'b1; unit_result = 32'hDEADBEEF;
    @(posedge clk); #1;
    unit_done = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || pipe_stall !== 1'b0 || busy_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: got wbv=%b stall=%b busy=%b want 0 0 0", wb_valid, pipe_stall, busy_rd_valid);
    end
  endtask

  task automatic test_async_reset();
    run_op(5'd12, 32'h11111111, 32'h22222222, 3'b011, 32'h0, -1, -1, -1, 4);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({pipe_stall, busy_rd_valid, wb_valid, unit_start} !== 4'b0 ||
        {unit_op_a, unit_op_b, busy_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset: got stall=%b busy=%b wbv=%b a=%h want all 0",
               pipe_stall, busy_rd_valid, wb_valid, unit_op_a);
    end
    @(negedge clk); reset = 1'b1;
    run_op(5'd3, 32'h3F800000, 32'h3F800000, 3'b000, 32'h3F800000, 3, -1, 4, 8);
    checks++;
    if (n_wbv !== 1 || wb_rd_seen !== 5'd3 || wb_data_seen !== 32'h3F800000) begin
      errors++;
      $display("FAIL post_reset_op: got n=%0d rd=%0d data=%h want 1 3 3f800000",
               n_wbv, wb_rd_seen, wb_data_seen);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [4:0]  rd;
      logic [31:0] a, b, res;
      logic [2:0]  rm;
      int d, rdelay, fmode, fat, fin, exp_n_stall, exp_last;
      logic dropped;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a = $urandom; b = $urandom; res = $urandom; rm = 3'($urandom_range(0, 4));
      d = $urandom_range(1, MAX_D);
      rdelay = $urandom_range(0, 3);
      fmode = $urandom_range(0, 3);
      fat = (fmode == 1) ? $urandom_range(1, d) : (fmode == 2) ? d + 1 : -1;
      dropped = (rd == 5'd0) || (fat >= 1 && fat <= d);
      fin = d + 1 + rdelay;
      exp_n_stall = dropped ? d + 1 : fin + 1;
      exp_last = dropped ? d : fin;
      run_op(rd, a, b, rm, res, d, fat, fin, fin + 4);
      checks++;
      if (lat_a !== a || lat_b !== b || lat_rm !== rm || lat_rd !== rd || start_at !== 1) begin
        errors++;
        $display("FAIL rnd%0d_issue: got a=%h b=%h rm=%0d rd=%0d start=%0d want %h %h %0d %0d 1",
                 it, lat_a, lat_b, lat_rm, lat_rd, start_at, a, b, rm, rd);
      end
      checks++;
      if (n_stall !== exp_n_stall || last_stall !== exp_last) begin
        errors++;
        $display("FAIL rnd%0d_stall: got n=%0d last=%0d want n=%0d last=%0d",
                 it, n_stall, last_stall, exp_n_stall, exp_last);
      end
      checks++;
      if (n_wbv !== (dropped ? 0 : rdelay + 1) || wb_unstable !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_wbcount: got n=%0d unstable=%b want n=%0d",
                 it, n_wbv, wb_unstable, dropped ? 0 : rdelay + 1);
      end
      if (!dropped) begin
        checks++;
        if (wb_data_seen !== res || wb_rd_seen !== rd || wbv_first !== d + 1) begin
          errors++;
          $display("FAIL rnd%0d_wbdata: got data=%h rd=%0d first=%0d want %h %0d %0d",
                   it, wb_data_seen, wb_rd_seen, wbv_first, res, rd, d + 1);
        end
      end
    end
  endtask

`ifdef FPLONG_WATCHDOG_EN
  task automatic test_watchdog();
    run_op(5'd9, $urandom, $urandom, 3'b000, 32'h12345678, 14, -1, 9, 18);
    checks++;
    if (n_wbv !== 1 || wbv_first !== 9 || wb_data_seen !== 32'h7FC00000 || wb_rd_seen !== 5'd9) begin
      errors++;
      $display("FAIL wd_wb: got n=%0d first=%0d data=%h rd=%0d want 1 9 7fc00000 9",
               n_wbv, wbv_first, wb_data_seen, wb_rd_seen);
    end
    checks++;
    if (n_err !== 9 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL wd_err: got cycles=%0d now=%b want 9 1", n_err, err_timeout);
    end
    checks++;
    if (last_stall !== 14 || n_busyv !== 9) begin
      errors++; $display("FAIL wd_drop: got stall_last=%0d busy=%0d want 14 9", last_stall, n_busyv);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fdiv_basic();
    test_wb_backpressure();
    test_flush_drop();
    test_done_flush_same();
    test_rd_zero();
    test_idle_done();
    test_async_reset();
    test_random();
`ifdef FPLONG_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
